// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line levels and parity types.
// Imported by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/line bundle between a frame producer (master) and the UART transmitter (slave).
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Data latch and bit counter for the UART transmitter. Presents the bit that
// will be on the line next cycle so the top can keep TX_OUT registered.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data_q,
    output logic                  next_bit,
    output logic                  last_bit
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_d;

    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    // The counter saturates on the last bit; the FSM leaves DATA on that cycle.
    always_comb begin
        cnt_d = bit_cnt;
        if (clear) begin
            cnt_d = '0;
        end else if (advance && !last_bit) begin
            cnt_d = bit_cnt + 1'b1;
        end
    end

    assign next_bit = data_q[cnt_d];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            bit_cnt <= '0;
        end else begin
            if (load) begin
                data_q <= data_in;
            end
            bit_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// One CLK cycle per bit; TX_OUT and Busy come straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);

    uart_state_e           state;
    uart_state_e           next_state;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  tx_d;
    logic                  busy_d;
    logic                  load;
    logic                  clear;
    logic                  advance;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  next_bit;
    logic                  last_bit;
    logic                  parity_bit;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .data_in  (bus.P_DATA),
        .clear    (clear),
        .advance  (advance),
        .data_q   (data_q),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    assign parity_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state  <= next_state;
            tx_q   <= tx_d;
            busy_q <= busy_d;
            if (load) begin
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
        end
    end

    // Outputs are decoded from next_state so the registered line level lines
    // up with the state the FSM is entering.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        clear      = 1'b0;
        advance    = 1'b0;
        tx_d       = IDLE_LEVEL;
        busy_d     = 1'b1;

        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    load       = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                clear      = 1'b1;
                next_state = DATA;
            end
            DATA: begin
                advance = 1'b1;
                if (last_bit) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        case (next_state)
            IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
            end
            START:   tx_d = START_BIT;
            DATA:    tx_d = next_bit;
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = STOP_BIT;
            default: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule
